// File: rtl/cpu_trace_buffer_if.sv
// Capture control, MiniMIPS debug bus and readout port of the trace buffer.
// The master side is the core/debug host; the slave side is cpu_trace_buffer.
interface cpu_trace_buffer_if #(
   parameter int DATA_W  = 32,
   parameter int CTRL_W  = 22,
   parameter int STATE_W = 4,
   parameter int DEPTH   = 64
);
   localparam int AW      = $clog2(DEPTH);
   localparam int ENTRY_W = STATE_W + CTRL_W + 3*DATA_W;

   logic               arm;
   logic [1:0]         mode;
   logic               trig_en;
   logic [DATA_W-1:0]  trig_pc;
   logic               force_trig;
   logic [STATE_W-1:0] dbg_state;
   logic [CTRL_W-1:0]  dbg_ctrl;
   logic [DATA_W-1:0]  dbg_pc;
   logic [DATA_W-1:0]  dbg_inst;
   logic [DATA_W-1:0]  dbg_alu_out;
   logic               rd_en;
   logic [AW-1:0]      rd_addr;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_valid;
   logic               busy;
   logic               triggered;
   logic               done;
   logic [AW:0]        count;
   logic [AW-1:0]      trig_index;

   modport master (
      output arm, mode, trig_en, trig_pc, force_trig,
             dbg_state, dbg_ctrl, dbg_pc, dbg_inst, dbg_alu_out,
             rd_en, rd_addr,
      input  rd_data, rd_valid, busy, triggered, done, count, trig_index
   );

   modport slave (
      input  arm, mode, trig_en, trig_pc, force_trig,
             dbg_state, dbg_ctrl, dbg_pc, dbg_inst, dbg_alu_out,
             rd_en, rd_addr,
      output rd_data, rd_valid, busy, triggered, done, count, trig_index
   );
endinterface

// File: rtl/cpu_trace_buffer.sv
// Circular trace capture of the MiniMIPS debug bus with PC-match / forced trigger,
// programmable post-trigger depth, and freeze-then-read by logical (oldest-first) index.
module cpu_trace_buffer #(
   parameter int DATA_W      = 32,
   parameter int CTRL_W      = 22,
   parameter int STATE_W     = 4,
   parameter int DEPTH       = 64,
   parameter int POST_TRIG   = 16,
   parameter int FETCH_STATE = 0
) (
   input logic               clk,
   input logic               reset,
   cpu_trace_buffer_if.slave io_bus
);
   localparam int AW      = $clog2(DEPTH);
   localparam int ENTRY_W = STATE_W + CTRL_W + 3*DATA_W;
   localparam logic [AW:0]        FULL      = (AW+1)'(DEPTH);
   localparam logic [AW-1:0]      POST_INIT = AW'(POST_TRIG);
   localparam logic [STATE_W-1:0] FETCH     = STATE_W'(FETCH_STATE);
   localparam bit                 NO_POST   = (POST_TRIG == 0);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST, S_DONE} state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_trig_ptr;
   logic [AW-1:0]      r_post_cnt;
   logic [AW:0]        r_count;
   logic               r_wrapped;
   logic               r_triggered;
   logic [DATA_W-1:0]  r_prev_pc;
   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [ENTRY_W-1:0] r_rd_data;
   logic               r_rd_valid;

   logic               w_busy;
   logic               w_done;
   logic               w_qual;
   logic               w_wr;
   logic               w_arm;
   logic               w_trig;
   logic               w_post_last;
   logic               w_rd_ok;
   logic [AW-1:0]      w_base;
   logic [AW-1:0]      w_rd_phys;

   assign w_busy = (r_state == S_PRE) || (r_state == S_POST);
   assign w_done = (r_state == S_DONE);
   assign w_arm  = io_bus.arm && ((r_state == S_IDLE) || w_done);
   assign w_wr   = w_busy && w_qual;

   always_comb begin
      w_qual = 1'b1;
      case (io_bus.mode)
         2'd1:    w_qual = (io_bus.dbg_state == FETCH);
         2'd2:    w_qual = (io_bus.dbg_pc != r_prev_pc);
         default: w_qual = 1'b1;
      endcase
   end

   // A forced trigger on a non-qualified cycle still latches wr_ptr: the next write is the trigger record.
   assign w_trig = (r_state == S_PRE) &&
                   ((io_bus.trig_en && w_qual && (io_bus.dbg_pc == io_bus.trig_pc)) ||
                    io_bus.force_trig);
   assign w_post_last = (r_state == S_POST) &&
                        ((r_post_cnt == '0) || (w_wr && (r_post_cnt == AW'(1))));

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_arm) w_state_nxt = S_PRE;
         S_PRE:   if (w_trig) w_state_nxt = NO_POST ? S_DONE : S_POST;
         S_POST:  if (w_post_last) w_state_nxt = S_DONE;
         S_DONE:  if (w_arm) w_state_nxt = S_PRE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_wr_ptr    <= '0;
         r_trig_ptr  <= '0;
         r_post_cnt  <= '0;
         r_count     <= '0;
         r_wrapped   <= 1'b0;
         r_triggered <= 1'b0;
         r_prev_pc   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_arm) begin
            r_wr_ptr    <= '0;
            r_trig_ptr  <= '0;
            r_post_cnt  <= '0;
            r_count     <= '0;
            r_wrapped   <= 1'b0;
            r_triggered <= 1'b0;
            r_prev_pc   <= '0;
         end else begin
            if (w_busy) r_prev_pc <= io_bus.dbg_pc;
            if (w_wr) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
               if (r_wr_ptr == '1) r_wrapped <= 1'b1;
               if (r_count != FULL) r_count <= r_count + 1'b1;
            end
            if (w_trig) begin
               r_triggered <= 1'b1;
               r_trig_ptr  <= r_wr_ptr;
               r_post_cnt  <= POST_INIT;
            end else if ((r_state == S_POST) && w_wr && (r_post_cnt != '0)) begin
               r_post_cnt <= r_post_cnt - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {io_bus.dbg_state, io_bus.dbg_ctrl, io_bus.dbg_pc,
                             io_bus.dbg_inst, io_bus.dbg_alu_out};
      end
   end

   // Once wrapped, the oldest record sits at wr_ptr; logical indices are relative to it.
   assign w_base    = r_wrapped ? r_wr_ptr : '0;
   assign w_rd_phys = w_base + io_bus.rd_addr;
   assign w_rd_ok   = ({1'b0, io_bus.rd_addr} < r_count);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_rd_valid <= io_bus.rd_en && w_done;
         if (io_bus.rd_en && w_done) begin
            r_rd_data <= w_rd_ok ? r_mem[w_rd_phys] : '0;
         end
      end
   end

   assign io_bus.rd_data    = r_rd_data;
   assign io_bus.rd_valid   = r_rd_valid;
   assign io_bus.busy       = w_busy;
   assign io_bus.triggered  = r_triggered;
   assign io_bus.done       = w_done;
   assign io_bus.count      = r_count;
   assign io_bus.trig_index = r_trig_ptr - w_base;
endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer with DEPTH=8, POST_TRIG=2.
module tb_cpu_trace_buffer;
   localparam int DATA_W  = 32;
   localparam int CTRL_W  = 22;
   localparam int STATE_W = 4;
   localparam int DEPTH   = 8;
   localparam int ENTRY_W = STATE_W + CTRL_W + 3*DATA_W;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   cpu_trace_buffer_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .STATE_W(STATE_W), .DEPTH(DEPTH)) bus ();

   cpu_trace_buffer #(
      .DATA_W(DATA_W), .CTRL_W(CTRL_W), .STATE_W(STATE_W), .DEPTH(DEPTH),
      .POST_TRIG(2), .FETCH_STATE(0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_dbg(input logic [3:0] st, input logic [31:0] pc);
      bus.dbg_state   = st;
      bus.dbg_pc      = pc;
      bus.dbg_inst    = {16'hC0DE, pc[15:0]};
      bus.dbg_alu_out = ~pc;
      bus.dbg_ctrl    = 22'(pc >> 2);
   endtask

   function automatic logic [ENTRY_W-1:0] exp_entry(input logic [3:0] st, input logic [31:0] pc);
      logic [15:0] lo;
      lo = pc[15:0];
      return {st, 22'(pc >> 2), pc, {16'hC0DE, lo}, ~pc};
   endfunction

   task automatic idle_inputs();
      bus.arm        = 1'b0;
      bus.force_trig = 1'b0;
      bus.rd_en      = 1'b0;
      bus.rd_addr    = '0;
      bus.mode       = 2'd0;
      bus.trig_en    = 1'b0;
      bus.trig_pc    = '0;
      set_dbg(4'd1, 32'h0);
   endtask

   task automatic do_arm();
      bus.arm = 1'b1;
      step();
      bus.arm = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [ENTRY_W-1:0] d, output logic v);
      bus.rd_en   = 1'b1;
      bus.rd_addr = a;
      step();
      d = bus.rd_data;
      v = bus.rd_valid;
      bus.rd_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      step();
      step();
      reset = 1'b0;
      n_checks++;
      if ({bus.busy, bus.triggered, bus.done, bus.rd_valid} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_flags: got busy/trig/done/rdv=%b expected 0000",
                  {bus.busy, bus.triggered, bus.done, bus.rd_valid});
      end
      n_checks++;
      if (bus.count !== 4'd0 || bus.trig_index !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_counters: got count=%0d trig_index=%0d expected 0/0", bus.count, bus.trig_index);
      end
      n_checks++;
      if (bus.rd_data !== '0) begin
         n_fail++;
         $display("FAIL reset_rd_data: got %0h expected 0", bus.rd_data);
      end
   endtask

   task automatic test_pc_trigger();
      logic [ENTRY_W-1:0] d;
      logic v;
      int j, trig_seen;
      bus.mode = 2'd0; bus.trig_en = 1'b1; bus.trig_pc = 32'h10;
      do_arm();
      n_checks++;
      if (bus.busy !== 1'b1) begin
         n_fail++; $display("FAIL t1_busy_after_arm: got %b expected 1", bus.busy);
      end
      j = 0; trig_seen = -1;
      while (!bus.done && j < 60) begin
         set_dbg(4'd2, 32'(j*4));
         step();
         if (bus.triggered && trig_seen < 0) trig_seen = j;
         j++;
      end
      n_checks++;
      if (j !== 7 || bus.busy !== 1'b0) begin
         n_fail++; $display("FAIL t1_done_cycle: got cycles=%0d busy=%b expected 7/0", j, bus.busy);
      end
      n_checks++;
      if (trig_seen !== 4) begin
         n_fail++; $display("FAIL t1_trig_cycle: got %0d expected 4", trig_seen);
      end
      n_checks++;
      if (bus.count !== 4'd7 || bus.trig_index !== 3'd4) begin
         n_fail++; $display("FAIL t1_count_tidx: got %0d/%0d expected 7/4", bus.count, bus.trig_index);
      end
      rd(3'd0, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp_entry(4'd2, 32'h00)) begin
         n_fail++; $display("FAIL t1_rd0: got v=%b %0h expected 1 %0h", v, d, exp_entry(4'd2, 32'h00));
      end
      step();
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL t1_rd_pulse: got rd_valid=%b expected 0", bus.rd_valid);
      end
      rd(3'd4, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp_entry(4'd2, 32'h10)) begin
         n_fail++; $display("FAIL t1_rd4: got v=%b %0h expected 1 %0h", v, d, exp_entry(4'd2, 32'h10));
      end
      rd(3'd7, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== '0) begin
         n_fail++; $display("FAIL t1_rd_beyond_count: got v=%b %0h expected 1 0", v, d);
      end
      // back-to-back reads, one result per cycle
      bus.rd_en = 1'b1; bus.rd_addr = 3'd1;
      step();
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_entry(4'd2, 32'h04)) begin
         n_fail++; $display("FAIL t1_b2b_first: got v=%b %0h expected 1 %0h", bus.rd_valid, bus.rd_data, exp_entry(4'd2, 32'h04));
      end
      bus.rd_addr = 3'd6;
      step();
      bus.rd_en = 1'b0;
      n_checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_entry(4'd2, 32'h18)) begin
         n_fail++; $display("FAIL t1_b2b_second: got v=%b %0h expected 1 %0h", bus.rd_valid, bus.rd_data, exp_entry(4'd2, 32'h18));
      end
   endtask

   task automatic test_wrap();
      logic [ENTRY_W-1:0] d;
      logic v;
      int j;
      bus.mode = 2'd0; bus.trig_en = 1'b1; bus.trig_pc = 32'h40;
      do_arm();
      n_checks++;
      if (bus.count !== 4'd0 || bus.done !== 1'b0 || bus.triggered !== 1'b0) begin
         n_fail++; $display("FAIL t2_rearm_clear: got count=%0d done=%b trig=%b expected 0/0/0", bus.count, bus.done, bus.triggered);
      end
      j = 0;
      while (!bus.done && j < 60) begin
         set_dbg(4'd3, 32'h10 + 32'(j*4));
         step();
         j++;
      end
      n_checks++;
      if (j !== 15) begin
         n_fail++; $display("FAIL t2_done_cycle: got %0d expected 15", j);
      end
      n_checks++;
      if (bus.count !== 4'd8 || bus.trig_index !== 3'd5) begin
         n_fail++; $display("FAIL t2_count_tidx: got %0d/%0d expected 8/5", bus.count, bus.trig_index);
      end
      rd(3'd0, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp_entry(4'd3, 32'h2C)) begin
         n_fail++; $display("FAIL t2_rd_oldest: got v=%b %0h expected 1 %0h", v, d, exp_entry(4'd3, 32'h2C));
      end
      rd(3'd5, d, v);
      n_checks++;
      if (d !== exp_entry(4'd3, 32'h40)) begin
         n_fail++; $display("FAIL t2_rd_trig: got %0h expected %0h", d, exp_entry(4'd3, 32'h40));
      end
      rd(3'd7, d, v);
      n_checks++;
      if (d !== exp_entry(4'd3, 32'h48)) begin
         n_fail++; $display("FAIL t2_rd_newest: got %0h expected %0h", d, exp_entry(4'd3, 32'h48));
      end
   endtask

   task automatic test_fetch_mode();
      logic [ENTRY_W-1:0] d;
      logic v;
      int j, trig_seen;
      bus.mode = 2'd1; bus.trig_en = 1'b0;
      do_arm();
      j = 0; trig_seen = -1;
      while (!bus.done && j < 60) begin
         set_dbg(4'(j % 4), 32'h100 + 32'(4*(j/4)));
         bus.force_trig = (j == 9);
         step();
         if (bus.triggered && trig_seen < 0) trig_seen = j;
         j++;
      end
      bus.force_trig = 1'b0;
      n_checks++;
      if (j !== 17 || trig_seen !== 9) begin
         n_fail++; $display("FAIL t3_timing: got done_cycles=%0d trig_cycle=%0d expected 17/9", j, trig_seen);
      end
      n_checks++;
      if (bus.count !== 4'd5 || bus.trig_index !== 3'd3) begin
         n_fail++; $display("FAIL t3_count_tidx: got %0d/%0d expected 5/3", bus.count, bus.trig_index);
      end
      for (int i = 0; i < 5; i++) begin
         rd(3'(i), d, v);
         n_checks++;
         if (v !== 1'b1 || d !== exp_entry(4'd0, 32'h100 + 32'(4*i))) begin
            n_fail++; $display("FAIL t3_rd%0d: got v=%b %0h expected 1 %0h", i, v, d, exp_entry(4'd0, 32'h100 + 32'(4*i)));
         end
      end
   endtask

   task automatic test_pc_change();
      logic [ENTRY_W-1:0] d;
      logic v;
      int j;
      bus.mode = 2'd2; bus.trig_en = 1'b1; bus.trig_pc = 32'h20C;
      do_arm();
      j = 0;
      while (!bus.done && j < 60) begin
         set_dbg(4'd5, 32'h200 + 32'(4*(j/3)));
         step();
         j++;
      end
      n_checks++;
      if (j !== 16 || bus.count !== 4'd6 || bus.trig_index !== 3'd3) begin
         n_fail++; $display("FAIL t4_summary: got cycles=%0d count=%0d tidx=%0d expected 16/6/3", j, bus.count, bus.trig_index);
      end
      for (int i = 0; i < 6; i++) begin
         rd(3'(i), d, v);
         n_checks++;
         if (v !== 1'b1 || d !== exp_entry(4'd5, 32'h200 + 32'(4*i))) begin
            n_fail++; $display("FAIL t4_rd%0d: got v=%b %0h expected 1 %0h", i, v, d, exp_entry(4'd5, 32'h200 + 32'(4*i)));
         end
      end
      rd(3'd6, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== '0) begin
         n_fail++; $display("FAIL t4_rd_beyond_count: got v=%b %0h expected 1 0", v, d);
      end
   endtask

   task automatic test_reset_in_post();
      bus.mode = 2'd0; bus.trig_en = 1'b1; bus.trig_pc = 32'h10;
      do_arm();
      for (int j = 0; j < 5; j++) begin
         set_dbg(4'd2, 32'(j*4));
         step();
      end
      n_checks++;
      if (bus.triggered !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
         n_fail++; $display("FAIL t5_in_post: got trig=%b busy=%b done=%b expected 1/1/0", bus.triggered, bus.busy, bus.done);
      end
      set_dbg(4'd2, 32'h14);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_checks++;
      if ({bus.busy, bus.done, bus.triggered} !== 3'b000 || bus.count !== 4'd0) begin
         n_fail++; $display("FAIL t5_after_reset: got busy/done/trig=%b count=%0d expected 000/0",
                            {bus.busy, bus.done, bus.triggered}, bus.count);
      end
      bus.rd_en = 1'b1; bus.rd_addr = 3'd0;
      step();
      bus.rd_en = 1'b0;
      n_checks++;
      if (bus.rd_valid !== 1'b0) begin
         n_fail++; $display("FAIL t5_rd_in_idle: got rd_valid=%b expected 0", bus.rd_valid);
      end
   endtask

   task automatic test_arm_force();
      logic [ENTRY_W-1:0] d;
      logic v;
      int j, trig_seen;
      bus.mode = 2'd0; bus.trig_en = 1'b1; bus.trig_pc = 32'h8;
      set_dbg(4'd2, 32'h8);
      bus.arm = 1'b1; bus.force_trig = 1'b1;
      step();
      bus.arm = 1'b0; bus.force_trig = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b1 || bus.triggered !== 1'b0) begin
         n_fail++; $display("FAIL t6_arm_wins: got busy=%b trig=%b expected 1/0", bus.busy, bus.triggered);
      end
      j = 0; trig_seen = -1;
      while (!bus.done && j < 60) begin
         set_dbg(4'd2, 32'(j*4));
         bus.rd_en = (j == 0);
         step();
         if (j == 0) begin
            n_checks++;
            if (bus.rd_valid !== 1'b0) begin
               n_fail++; $display("FAIL t6_rd_in_pre: got rd_valid=%b expected 0", bus.rd_valid);
            end
         end
         if (bus.triggered && trig_seen < 0) trig_seen = j;
         j++;
      end
      bus.rd_en = 1'b0;
      n_checks++;
      if (j !== 5 || trig_seen !== 2) begin
         n_fail++; $display("FAIL t6_timing: got done_cycles=%0d trig_cycle=%0d expected 5/2", j, trig_seen);
      end
      n_checks++;
      if (bus.count !== 4'd5 || bus.trig_index !== 3'd2) begin
         n_fail++; $display("FAIL t6_count_tidx: got %0d/%0d expected 5/2", bus.count, bus.trig_index);
      end
      rd(3'd2, d, v);
      n_checks++;
      if (v !== 1'b1 || d !== exp_entry(4'd2, 32'h08)) begin
         n_fail++; $display("FAIL t6_rd_trig: got v=%b %0h expected 1 %0h", v, d, exp_entry(4'd2, 32'h08));
      end
   endtask

   initial begin
      test_reset();
      test_pc_trigger();
      test_wrap();
      test_fetch_mode();
      test_pc_change();
      test_reset_in_post();
      test_arm_force();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
